// File: rtl/ip_crpr_pkg.sv
// Shared definitions for the credit-return scheduler.
//   PD_NUM_W    : width of a posted data credit count
//   P_ENTRY_W   : posted FIFO entry width {pd_cr, pd_num}
//   NP_ENTRY_W  : non-posted FIFO entry width {npd_cr}
//   rr_next()   : round-robin successor, wraps modulo n (n need not be a power of 2)
package ip_crpr_pkg;

  localparam int unsigned PD_NUM_W   = 8;
  localparam int unsigned P_ENTRY_W  = PD_NUM_W + 1;
  localparam int unsigned NP_ENTRY_W = 1;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/ip_crpr_fifo.sv
// Synchronous FIFO holding queued credit-return events for one port and one class.
//   clk, rstn : clock, asynchronous active-low reset (discards all entries)
//   push_i    : write wdata_i; accepted when not full, or when full with a same-cycle pop
//   pop_i     : remove the head entry (ignored when empty)
//   rdata_o   : head entry, valid while empty_o is low
//   full_o    : Depth entries held
//   empty_o   : no entries held
module ip_crpr_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // One extra pointer bit separates full from empty when the addresses match.
  logic [AddrW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             wr_en, rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign rd_en   = pop_i & ~empty_o;
  // A pop frees the head slot this edge, so a push into a full FIFO still fits.
  assign wr_en   = push_i & (~full_o | rd_en);
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{AddrW{1'b0}}, wr_en};
    rptr_d = rptr_q + {{AddrW{1'b0}}, rd_en};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/ip_crpr_sched.sv
// Credit-return scheduler: merges per-port credit returns onto the single core credit port.
// Each port has one posted and one non-posted event FIFO; each class has its own
// round-robin arbiter that pops at most one event per cycle into registered outputs.
//   ph_cr_in/pd_cr_in/pd_num_in : posted returns per port (data qualified by header)
//   nph_cr_in/npd_cr_in         : non-posted returns per port (data qualified by header)
//   ph_cr/pd_cr/pd_num          : merged posted return, one-cycle pulse per event
//   nph_cr/npd_cr               : merged non-posted return, one-cycle pulse per event
//   ovf/ovf_clr                 : sticky per-port drop flags and their clear
//   busy                        : registered OR of all FIFO non-empty flags
// Optional: define IP_CRPR_SCHED_STATS_EN to add saturating output counters
//   ph_tot/pd_tot/nph_tot/npd_tot (cleared by reset and ovf_clr).
module ip_crpr_sched
  import ip_crpr_pkg::*;
#(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_PORTS-1:0]           ph_cr_in,
  input  logic [N_PORTS-1:0]           pd_cr_in,
  input  logic [PD_NUM_W*N_PORTS-1:0]  pd_num_in,
  input  logic [N_PORTS-1:0]           nph_cr_in,
  input  logic [N_PORTS-1:0]           npd_cr_in,
  output logic                         ph_cr,
  output logic                         pd_cr,
  output logic [PD_NUM_W-1:0]          pd_num,
  output logic                         nph_cr,
  output logic                         npd_cr,
  input  logic                         ovf_clr,
  output logic [N_PORTS-1:0]           ovf,
  output logic                         busy
`ifdef IP_CRPR_SCHED_STATS_EN
  ,
  output logic [15:0]                  ph_tot,
  output logic [15:0]                  pd_tot,
  output logic [15:0]                  nph_tot,
  output logic [15:0]                  npd_tot
`endif
);

  localparam int unsigned IdxW = $clog2(N_PORTS);
  typedef logic [IdxW-1:0] idx_t;

  logic [N_PORTS-1:0]    p_empty, p_full, p_pop, p_drop;
  logic [N_PORTS-1:0]    np_empty, np_full, np_pop, np_drop;
  logic [P_ENTRY_W-1:0]  p_rdata  [N_PORTS];
  logic [NP_ENTRY_W-1:0] np_rdata [N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    logic [P_ENTRY_W-1:0] p_wdata;

    // Count is forced to zero when the data-valid bit is low.
    assign p_wdata = pd_cr_in[i] ? {1'b1, pd_num_in[PD_NUM_W*i +: PD_NUM_W]} : '0;

    ip_crpr_fifo #(
      .Width (P_ENTRY_W),
      .Depth (FIFO_DEPTH)
    ) u_p_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (ph_cr_in[i]),
      .wdata_i (p_wdata),
      .pop_i   (p_pop[i]),
      .rdata_o (p_rdata[i]),
      .full_o  (p_full[i]),
      .empty_o (p_empty[i])
    );

    ip_crpr_fifo #(
      .Width (NP_ENTRY_W),
      .Depth (FIFO_DEPTH)
    ) u_np_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (nph_cr_in[i]),
      .wdata_i (npd_cr_in[i]),
      .pop_i   (np_pop[i]),
      .rdata_o (np_rdata[i]),
      .full_o  (np_full[i]),
      .empty_o (np_empty[i])
    );
  end

  assign p_drop  = ph_cr_in  & p_full  & ~p_pop;
  assign np_drop = nph_cr_in & np_full & ~np_pop;

  // Returns {grant_valid, grant_index}: first non-empty FIFO after ptr, wrapping.
  function automatic logic [IdxW:0] rr_pick(input logic [N_PORTS-1:0] empty, input idx_t ptr);
    logic [IdxW:0] res;
    idx_t          j;
    res = {1'b0, ptr};
    j   = ptr;
    for (int k = 0; k < N_PORTS; k++) begin
      j = idx_t'(rr_next(32'(j), N_PORTS));
      if (!res[IdxW] && !empty[j]) begin
        res = {1'b1, j};
      end
    end
    return res;
  endfunction

  logic [IdxW:0]         p_pick, np_pick;
  idx_t                  p_ptr_q, p_ptr_d, np_ptr_q, np_ptr_d;
  logic                  ph_cr_q, ph_cr_d, pd_cr_q, pd_cr_d, nph_cr_q, nph_cr_d;
  logic                  npd_cr_q, npd_cr_d, busy_q, busy_d;
  logic [PD_NUM_W-1:0]   pd_num_q, pd_num_d;
  logic [N_PORTS-1:0]    ovf_q, ovf_d;

  always_comb begin
    p_pick   = rr_pick(p_empty, p_ptr_q);
    np_pick  = rr_pick(np_empty, np_ptr_q);
    p_pop    = '0;
    np_pop   = '0;
    p_ptr_d  = p_ptr_q;
    np_ptr_d = np_ptr_q;
    ph_cr_d  = p_pick[IdxW];
    pd_cr_d  = 1'b0;
    pd_num_d = '0;
    nph_cr_d = np_pick[IdxW];
    npd_cr_d = 1'b0;
    if (p_pick[IdxW]) begin
      p_pop[p_pick[IdxW-1:0]] = 1'b1;
      p_ptr_d                 = p_pick[IdxW-1:0];
      {pd_cr_d, pd_num_d}     = p_rdata[p_pick[IdxW-1:0]];
    end
    if (np_pick[IdxW]) begin
      np_pop[np_pick[IdxW-1:0]] = 1'b1;
      np_ptr_d                  = np_pick[IdxW-1:0];
      npd_cr_d                  = np_rdata[np_pick[IdxW-1:0]][0];
    end
    // A drop in the same cycle as a clear must survive.
    ovf_d  = (ovf_clr ? '0 : ovf_q) | p_drop | np_drop;
    busy_d = ~&(p_empty & np_empty);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_ptr_q  <= idx_t'(N_PORTS - 1);
      np_ptr_q <= idx_t'(N_PORTS - 1);
      ph_cr_q  <= 1'b0;
      pd_cr_q  <= 1'b0;
      pd_num_q <= '0;
      nph_cr_q <= 1'b0;
      npd_cr_q <= 1'b0;
      ovf_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      p_ptr_q  <= p_ptr_d;
      np_ptr_q <= np_ptr_d;
      ph_cr_q  <= ph_cr_d;
      pd_cr_q  <= pd_cr_d;
      pd_num_q <= pd_num_d;
      nph_cr_q <= nph_cr_d;
      npd_cr_q <= npd_cr_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign ph_cr  = ph_cr_q;
  assign pd_cr  = pd_cr_q;
  assign pd_num = pd_num_q;
  assign nph_cr = nph_cr_q;
  assign npd_cr = npd_cr_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;

`ifdef IP_CRPR_SCHED_STATS_EN
  logic [15:0] ph_tot_q, pd_tot_q, nph_tot_q, npd_tot_q;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph_tot_q  <= '0;
      pd_tot_q  <= '0;
      nph_tot_q <= '0;
      npd_tot_q <= '0;
    end else if (ovf_clr) begin
      ph_tot_q  <= '0;
      pd_tot_q  <= '0;
      nph_tot_q <= '0;
      npd_tot_q <= '0;
    end else begin
      ph_tot_q  <= sat_add(ph_tot_q, {15'd0, ph_cr_q});
      pd_tot_q  <= sat_add(pd_tot_q, pd_cr_q ? {8'd0, pd_num_q} : 16'd0);
      nph_tot_q <= sat_add(nph_tot_q, {15'd0, nph_cr_q});
      npd_tot_q <= sat_add(npd_tot_q, {15'd0, npd_cr_q});
    end
  end

  assign ph_tot  = ph_tot_q;
  assign pd_tot  = pd_tot_q;
  assign nph_tot = nph_tot_q;
  assign npd_tot = npd_tot_q;
`endif

endmodule

// File: tb/tb_ip_crpr_sched.sv
// Self-checking bench for ip_crpr_sched (default build, 4 ports, depth 4).
// A queue-based model predicts every registered output each cycle; directed
// tests add hand-computed literal expectations.
module tb_ip_crpr_sched;

  localparam int N = 4;
  localparam int D = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [N-1:0]     ph_cr_in, pd_cr_in, nph_cr_in, npd_cr_in;
  logic [8*N-1:0]   pd_num_in;
  logic             ph_cr, pd_cr, nph_cr, npd_cr, ovf_clr, busy;
  logic [7:0]       pd_num;
  logic [N-1:0]     ovf;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ip_crpr_sched #(
    .N_PORTS    (N),
    .FIFO_DEPTH (D)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ph_cr_in  (ph_cr_in),
    .pd_cr_in  (pd_cr_in),
    .pd_num_in (pd_num_in),
    .nph_cr_in (nph_cr_in),
    .npd_cr_in (npd_cr_in),
    .ph_cr     (ph_cr),
    .pd_cr     (pd_cr),
    .pd_num    (pd_num),
    .nph_cr    (nph_cr),
    .npd_cr    (npd_cr),
    .ovf_clr   (ovf_clr),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [8:0]   pq  [N][$];
  logic         npq [N][$];
  int           p_ptr = N - 1;
  int           np_ptr = N - 1;
  logic         e_ph = 1'b0, e_pd = 1'b0, e_nph = 1'b0, e_npd = 1'b0, e_busy = 1'b0;
  logic [7:0]   e_num = 8'd0;
  logic [N-1:0] e_ovf = '0;
  logic [N-1:0] m_drop;
  logic [8:0]   m_ent;
  int           m_j;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        pq[i].delete();
        npq[i].delete();
      end
      p_ptr = N - 1; np_ptr = N - 1;
      e_ph = 0; e_pd = 0; e_num = 0; e_nph = 0; e_npd = 0; e_ovf = '0; e_busy = 0;
    end else begin
      e_busy = 1'b0;
      for (int i = 0; i < N; i++)
        if (pq[i].size() != 0 || npq[i].size() != 0) e_busy = 1'b1;
      e_ph = 0; e_pd = 0; e_num = 0;
      for (int k = 1; k <= N; k++) begin
        m_j = (p_ptr + k) % N;
        if (!e_ph && pq[m_j].size() != 0) begin
          m_ent = pq[m_j].pop_front();
          e_ph = 1; e_pd = m_ent[8]; e_num = m_ent[7:0]; p_ptr = m_j;
        end
      end
      e_nph = 0; e_npd = 0;
      for (int k = 1; k <= N; k++) begin
        m_j = (np_ptr + k) % N;
        if (!e_nph && npq[m_j].size() != 0) begin
          e_npd = npq[m_j].pop_front();
          e_nph = 1; np_ptr = m_j;
        end
      end
      // Pops happen first, so a full queue popped this cycle still takes the push.
      m_drop = '0;
      for (int i = 0; i < N; i++) begin
        if (ph_cr_in[i]) begin
          if (pq[i].size() < D) pq[i].push_back(pd_cr_in[i] ? {1'b1, pd_num_in[8*i +: 8]} : 9'd0);
          else m_drop[i] = 1'b1;
        end
        if (nph_cr_in[i]) begin
          if (npq[i].size() < D) npq[i].push_back(npd_cr_in[i]);
          else m_drop[i] = 1'b1;
        end
      end
      e_ovf = (ovf_clr ? '0 : e_ovf) | m_drop;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("ph_cr",  {31'd0, ph_cr},  {31'd0, e_ph});
      check("pd_cr",  {31'd0, pd_cr},  {31'd0, e_pd});
      check("pd_num", {24'd0, pd_num}, {24'd0, e_num});
      check("nph_cr", {31'd0, nph_cr}, {31'd0, e_nph});
      check("npd_cr", {31'd0, npd_cr}, {31'd0, e_npd});
      check("ovf",    {28'd0, ovf},    {28'd0, e_ovf});
      check("busy",   {31'd0, busy},   {31'd0, e_busy});
    end
  end

  int ph_cnt = 0;
  int nph_cnt = 0;
  always @(negedge clk) begin
    if (ph_cr === 1'b1) ph_cnt++;
    if (nph_cr === 1'b1) nph_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    ph_cr_in = '0; pd_cr_in = '0; pd_num_in = '0; nph_cr_in = '0; npd_cr_in = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  int n0;
  int m0;

  initial begin
    idle();
    ovf_clr = 1'b0;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    chk_en = 1'b1;

    // Reset state
    check("rst_ph_cr", {31'd0, ph_cr}, 32'd0);
    check("rst_pd_num", {24'd0, pd_num}, 32'd0);
    check("rst_nph_cr", {31'd0, nph_cr}, 32'd0);
    check("rst_ovf", {28'd0, ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Single event on port 2
    ph_cr_in = 4'b0100; pd_cr_in = 4'b0100; pd_num_in[8*2 +: 8] = 8'h10;
    tick(); idle();
    check("single_t1_ph", {31'd0, ph_cr}, 32'd0);
    tick();
    check("single_t2_ph", {31'd0, ph_cr}, 32'd1);
    check("single_t2_pd", {31'd0, pd_cr}, 32'd1);
    check("single_t2_num", {24'd0, pd_num}, 32'h10);
    check("single_t2_nph", {31'd0, nph_cr}, 32'd0);
    tick();
    check("single_t3_ph", {31'd0, ph_cr}, 32'd0);

    // Simultaneous pushes from all ports, from reset pointer
    do_reset();
    ph_cr_in = 4'b1111; pd_cr_in = 4'b1111;
    pd_num_in = {8'd4, 8'd3, 8'd2, 8'd1};
    tick(); idle();
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("simul_num", {24'd0, pd_num}, 32'(k));
    end
    check("simul_busy_last", {31'd0, busy}, 32'd1);
    tick();
    check("simul_busy_fall", {31'd0, busy}, 32'd0);
    check("simul_ph_end", {31'd0, ph_cr}, 32'd0);

    // Round-robin: ports 0 and 3 push every cycle
    for (int c = 0; c < 4; c++) begin
      ph_cr_in = 4'b1001; pd_cr_in = 4'b1001; pd_num_in = '0;
      pd_num_in[7:0] = 8'(c);
      pd_num_in[8*3 +: 8] = 8'h30 + 8'(c);
      tick();
      if (c == 1) check("rr_g0", {24'd0, pd_num}, 32'h00);
      if (c == 2) check("rr_g1", {24'd0, pd_num}, 32'h30);
      if (c == 3) check("rr_g2", {24'd0, pd_num}, 32'h01);
    end
    idle();
    tick();
    check("rr_g3", {24'd0, pd_num}, 32'h31);
    repeat (10) tick();
    check("rr_no_ovf", {28'd0, ovf}, 32'd0);

    // Overflow: all NP ports saturating for 6 cycles
    do_reset();
    n0 = nph_cnt;
    for (int c = 0; c < 6; c++) begin
      nph_cr_in = 4'b1111;
      npd_cr_in = (c % 2 == 1) ? 4'b0010 : 4'b1101;
      tick();
    end
    check("ovf_bit1", {31'd0, ovf[1]}, 32'd1);
    check("ovf_vec", {28'd0, ovf}, 32'b1110);
    idle();
    repeat (30) tick();
    check("ovf_accepted", 32'(nph_cnt - n0), 32'd21);
    check("ovf_sticky", {28'd0, ovf}, 32'b1110);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", {28'd0, ovf}, 32'd0);

    // Independence and data qualification
    ph_cr_in = 4'b0001; pd_cr_in = 4'b0000; pd_num_in[7:0] = 8'hFF;
    nph_cr_in = 4'b0100; npd_cr_in = 4'b0100;
    tick(); idle();
    tick();
    check("ind_ph", {31'd0, ph_cr}, 32'd1);
    check("ind_nph", {31'd0, nph_cr}, 32'd1);
    check("ind_pd", {31'd0, pd_cr}, 32'd0);
    check("ind_num", {24'd0, pd_num}, 32'd0);
    check("ind_npd", {31'd0, npd_cr}, 32'd1);
    repeat (3) tick();

    // Reset mid-traffic with 3 entries queued
    do_reset();
    ph_cr_in = 4'b0111; pd_cr_in = 4'b0111; pd_num_in = {8'd0, 8'd3, 8'd2, 8'd1};
    tick(); idle();
    ph_cr_in = 4'b1000; pd_cr_in = 4'b1000; pd_num_in[8*3 +: 8] = 8'd4;
    tick(); idle();
    check("mid_ph_before", {31'd0, ph_cr}, 32'd1);
    check("mid_num_before", {24'd0, pd_num}, 32'd1);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid_ph_async", {31'd0, ph_cr}, 32'd0);
    check("mid_num_async", {24'd0, pd_num}, 32'd0);
    check("mid_busy_async", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    m0 = ph_cnt;
    repeat (8) tick();
    check("mid_no_stale", 32'(ph_cnt - m0), 32'd0);
    check("mid_busy_idle", {31'd0, busy}, 32'd0);
    ph_cr_in = 4'b1111; pd_cr_in = 4'b1111; pd_num_in = {8'd8, 8'd7, 8'd6, 8'd5};
    tick(); idle();
    tick();
    check("mid_ptr_first", {24'd0, pd_num}, 32'd5);
    tick();
    check("mid_ptr_second", {24'd0, pd_num}, 32'd6);
    repeat (6) tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
